// File: rtl/trig_buffer_manager_pkg.sv
// Shared types and constants for the trigger buffer manager.
package trig_buffer_manager_pkg;

  // Trigger FSM: idle and waiting for a request, or in post-trigger holdoff.
  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StHoldoff = 1'b1
  } state_e;

  // Statistics counter widths.
  localparam int unsigned DeadCntW = 32;
  localparam int unsigned LostCntW = 16;

endpackage

// File: rtl/trig_buf_alloc.sv
// Circular first-free search over the buffer HOLD vector, starting at ptr_i.
module trig_buf_alloc #(
  parameter int unsigned NUM_BUF = 4,
  parameter int unsigned BUF_W   = 2
) (
  input  logic [NUM_BUF-1:0] hold_i,
  input  logic [BUF_W-1:0]   ptr_i,
  output logic [BUF_W-1:0]   idx_o,
  output logic               any_free_o
);

  // Walk NUM_BUF slots from ptr_i with wrap; the first clear HOLD bit wins.
  always_comb begin
    int unsigned slot;
    logic        found;
    idx_o = '0;
    found = 1'b0;
    slot  = 0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      slot = (32'(ptr_i) + i) % NUM_BUF;
      if (!found && !hold_i[slot]) begin
        found = 1'b1;
        idx_o = BUF_W'(slot);
      end
    end
    any_free_o = found;
  end

endmodule

// File: rtl/trig_buffer_manager.sv
// Trigger arbitration and digitizer buffer allocation with holdoff, dead-time
// and lost-trigger statistics.
module trig_buffer_manager
  import trig_buffer_manager_pkg::*;
#(
  parameter int unsigned NUM_BUF   = 4,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned HOLDOFF_W = 8,
  localparam int unsigned BUF_W    = (NUM_BUF > 2) ? $clog2(NUM_BUF) : 1
) (
  input  logic                 clk250_i,
  input  logic                 rst_n_i,
  input  logic [NUM_SRC-1:0]   trig_i,
  input  logic [NUM_SRC-1:0]   src_mask_i,
  input  logic [HOLDOFF_W-1:0] holdoff_i,
  input  logic                 clear_i,
  input  logic [BUF_W-1:0]     clear_buffer_i,
  output logic                 digitize_o,
  output logic [BUF_W-1:0]     digitize_buffer_o,
  output logic [NUM_SRC-1:0]   digitize_source_o,
  output logic [NUM_BUF-1:0]   hold_o,
  output logic                 dead_o,
  output logic [DeadCntW-1:0]  dead_count_o,
  output logic [LostCntW-1:0]  lost_count_o
);

  state_e               state_q, state_d;
  logic [HOLDOFF_W-1:0] cnt_q, cnt_d;
  logic [BUF_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [NUM_BUF-1:0]   hold_q, hold_d;
  logic                 dig_q, dig_d;
  logic [BUF_W-1:0]     dig_buf_q, dig_buf_d;
  logic [NUM_SRC-1:0]   dig_src_q, dig_src_d;
  logic                 dead_q, dead_d;
  logic [DeadCntW-1:0]  dead_cnt_q, dead_cnt_d;
  logic [LostCntW-1:0]  lost_cnt_q, lost_cnt_d;

  logic [NUM_SRC-1:0]   eff;
  logic [BUF_W-1:0]     alloc_idx;
  logic                 any_free;

  assign eff = trig_i & src_mask_i;

  // Search uses HOLD as registered, so a same-cycle clear cannot free a slot.
  trig_buf_alloc #(
    .NUM_BUF (NUM_BUF),
    .BUF_W   (BUF_W)
  ) u_alloc (
    .hold_i     (hold_q),
    .ptr_i      (wr_ptr_q),
    .idx_o      (alloc_idx),
    .any_free_o (any_free)
  );

  // Next-state: FSM, buffer allocation/release and saturating statistics.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_ptr_d   = wr_ptr_q;
    hold_d     = hold_q;
    dig_d      = 1'b0;
    dig_buf_d  = dig_buf_q;
    dig_src_d  = dig_src_q;
    lost_cnt_d = lost_cnt_q;
    dead_cnt_d = dead_cnt_q;

    if (clear_i && (32'(clear_buffer_i) < NUM_BUF)) begin
      hold_d[clear_buffer_i] = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (|eff) begin
          if (any_free) begin
            dig_d             = 1'b1;
            dig_buf_d         = alloc_idx;
            dig_src_d         = eff;
            hold_d[alloc_idx] = 1'b1;
            wr_ptr_d          = (32'(alloc_idx) == NUM_BUF - 1) ? '0 : alloc_idx + BUF_W'(1);
            if (holdoff_i != '0) begin
              state_d = StHoldoff;
              cnt_d   = holdoff_i;
            end
          end else if (lost_cnt_q != '1) begin
            lost_cnt_d = lost_cnt_q + LostCntW'(1);
          end
        end
      end
      StHoldoff: begin
        if (cnt_q <= HOLDOFF_W'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - HOLDOFF_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so dead_o lines up with the state/HOLD it describes.
    dead_d = (state_d == StHoldoff) || (&hold_d);

    if (dead_q && (dead_cnt_q != '1)) begin
      dead_cnt_d = dead_cnt_q + DeadCntW'(1);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk250_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      hold_q     <= '0;
      dig_q      <= 1'b0;
      dig_buf_q  <= '0;
      dig_src_q  <= '0;
      dead_q     <= 1'b0;
      dead_cnt_q <= '0;
      lost_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      hold_q     <= hold_d;
      dig_q      <= dig_d;
      dig_buf_q  <= dig_buf_d;
      dig_src_q  <= dig_src_d;
      dead_q     <= dead_d;
      dead_cnt_q <= dead_cnt_d;
      lost_cnt_q <= lost_cnt_d;
    end
  end

  assign digitize_o        = dig_q;
  assign digitize_buffer_o = dig_buf_q;
  assign digitize_source_o = dig_src_q;
  assign hold_o            = hold_q;
  assign dead_o            = dead_q;
  assign dead_count_o      = dead_cnt_q;
  assign lost_count_o      = lost_cnt_q;

endmodule

// File: tb/tb_trig_buffer_manager.sv
// Directed bench: expected digitize events are queued when triggers are
// driven and matched by a monitor whenever digitize_o pulses.
module tb_trig_buffer_manager;

  logic        clk;
  logic        rst_n;
  logic [3:0]  trig;
  logic [3:0]  mask;
  logic [7:0]  holdoff;
  logic        clr;
  logic [1:0]  clr_buf;
  logic        digitize;
  logic [1:0]  dig_buf;
  logic [3:0]  dig_src;
  logic [3:0]  hold;
  logic        dead;
  logic [31:0] dead_cnt;
  logic [15:0] lost_cnt;

  typedef struct {
    logic [1:0] bidx;
    logic [3:0] src;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  trig_buffer_manager #(
    .NUM_BUF   (4),
    .NUM_SRC   (4),
    .HOLDOFF_W (8)
  ) dut (
    .clk250_i          (clk),
    .rst_n_i           (rst_n),
    .trig_i            (trig),
    .src_mask_i        (mask),
    .holdoff_i         (holdoff),
    .clear_i           (clr),
    .clear_buffer_i    (clr_buf),
    .digitize_o        (digitize),
    .digitize_buffer_o (dig_buf),
    .digitize_source_o (dig_src),
    .hold_o            (hold),
    .dead_o            (dead),
    .dead_count_o      (dead_cnt),
    .lost_count_o      (lost_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] b, input logic [3:0] s);
    exp_t e;
    e.bidx = b;
    e.src  = s;
    exp_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_dig"}, digitize, 0);
    check({tag, "_buf"}, dig_buf, 0);
    check({tag, "_src"}, dig_src, 0);
    check({tag, "_hold"}, hold, 0);
    check({tag, "_dead"}, dead, 0);
    check({tag, "_deadcnt"}, dead_cnt, 0);
    check({tag, "_lost"}, lost_cnt, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (digitize === 1'b1) begin
      check("pulse_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("dig_buffer", dig_buf, e.bidx);
        check("dig_source", dig_src, e.src);
      end
    end
  end

  initial begin
    rst_n   = 1'b1;
    trig    = '0;
    mask    = 4'b1111;
    holdoff = 8'd4;
    clr     = 1'b0;
    clr_buf = '0;
    #2;
    do_reset();

    // Single trigger with holdoff 4; triggers during holdoff are ignored.
    trig = 4'b0001;
    push(2'd0, 4'b0001);
    tick();
    check("t1_pulse", digitize, 1);
    check("t1_hold", hold, 4'b0001);
    check("t1_dead0", dead, 1);
    trig = 4'b0010;
    for (int i = 1; i < 4; i++) begin
      tick();
      check("t1_dead_hi", dead, 1);
      check("t1_no_pulse", digitize, 0);
    end
    trig = '0;
    tick();
    check("t1_dead_lo", dead, 0);
    check("t1_deadcnt", dead_cnt, 4);
    check("t1_lost_holdoff", lost_cnt, 0);
    check("t1_hold_end", hold, 4'b0001);

    // Back-to-back accepts with holdoff 0 until full; fifth is lost.
    do_reset();
    holdoff = 8'd0;
    trig    = 4'b0010;
    for (int i = 0; i < 4; i++) push(2'(i), 4'b0010);
    for (int i = 0; i < 5; i++) tick();
    trig = '0;
    check("t2_hold", hold, 4'b1111);
    check("t2_lost", lost_cnt, 1);
    check("t2_dead", dead, 1);
    check("t2_no_pulse", digitize, 0);

    // Release buffer 1, then a trigger lands there.
    clr     = 1'b1;
    clr_buf = 2'd1;
    tick();
    clr = 1'b0;
    check("t3_hold_clr", hold, 4'b1101);
    check("t3_dead_clr", dead, 0);
    trig = 4'b0100;
    push(2'd1, 4'b0100);
    tick();
    trig = '0;
    check("t3_pulse", digitize, 1);
    check("t3_hold", hold, 4'b1111);

    // Full + clear + trigger in one cycle: lost, bit still cleared.
    clr     = 1'b1;
    clr_buf = 2'd2;
    trig    = 4'b1000;
    tick();
    clr  = 1'b0;
    trig = '0;
    check("t4_no_pulse", digitize, 0);
    check("t4_lost", lost_cnt, 2);
    check("t4_hold", hold, 4'b1011);
    trig = 4'b1000;
    push(2'd2, 4'b1000);
    tick();
    trig = '0;
    check("t4_pulse", digitize, 1);
    check("t4_hold_full", hold, 4'b1111);

    // Source masking.
    clr     = 1'b1;
    clr_buf = 2'd0;
    tick();
    clr_buf = 2'd3;
    tick();
    clr = 1'b0;
    check("t5_hold_clr", hold, 4'b0110);
    trig = 4'b1111;
    mask = 4'b0101;
    push(2'd3, 4'b0101);
    tick();
    check("t5_src", dig_src, 4'b0101);
    check("t5_hold", hold, 4'b1110);
    mask = 4'b0000;
    tick();
    tick();
    check("t5_mask0_nopulse", digitize, 0);
    check("t5_mask0_hold", hold, 4'b1110);
    check("t5_mask0_lost", lost_cnt, 2);
    mask = 4'b1111;
    trig = 4'b0001;
    push(2'd0, 4'b0001);
    tick();
    check("t5_fill_hold", hold, 4'b1111);
    mask = 4'b0000;
    trig = 4'b1111;
    tick();
    check("t5_full_mask0_lost", lost_cnt, 2);
    trig = '0;
    mask = 4'b1111;

    // Reset asserted mid-holdoff with two buffers held.
    do_reset();
    holdoff = 8'd0;
    trig    = 4'b0001;
    push(2'd0, 4'b0001);
    tick();
    holdoff = 8'd10;
    push(2'd1, 4'b0001);
    tick();
    trig = '0;
    check("t6_hold", hold, 4'b0011);
    check("t6_dead", dead, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("t6_async");
    tick();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    check("t6_no_pulse", digitize, 0);
    check("t6_hold_after", hold, 0);
    check("t6_dead_after", dead, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: observed timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/trig_buffer_manager.md
TRIG_BUFFER_MANAGER -- requirements
Module: trig_buffer_manager

Interface
REQ-001 SHALL have parameter NUM_BUF, default 4, number of digitizer buffers (2..16).
REQ-002 SHALL have parameter NUM_SRC, default 4, number of trigger sources (1..16).
REQ-003 SHALL have parameter HOLDOFF_W, default 8, width of the holdoff setting.
REQ-004 SHALL derive BUF_W = max(1, clog2(NUM_BUF)).
REQ-005 clk250_i  in  1  sole clock; all logic on its rising edge.
REQ-006 rst_n_i  in  1  reset, asynchronous and active-low.
REQ-007 trig_i  in  NUM_SRC  level-sampled trigger requests, one per source.
REQ-008 src_mask_i  in  NUM_SRC  1 = source enabled.
REQ-009 holdoff_i  in  HOLDOFF_W  post-trigger holdoff, in clocks.
REQ-010 clear_i  in  1  single-cycle strobe releasing one buffer.
REQ-011 clear_buffer_i  in  BUF_W  buffer index released by clear_i.
REQ-012 digitize_o  out  1  single-cycle pulse per accepted trigger.
REQ-013 digitize_buffer_o  out  BUF_W  buffer allocated; valid with digitize_o, held until next accept.
REQ-014 digitize_source_o  out  NUM_SRC  masked trigger vector that caused the accept.
REQ-015 hold_o  out  NUM_BUF  per-buffer HOLD; 1 = buffer occupied.
REQ-016 dead_o  out  1  1 when no trigger can be accepted.
REQ-017 dead_count_o  out  32  saturating count of clocks with dead_o = 1.
REQ-018 lost_count_o  out  16  saturating count of triggers rejected because all buffers were full.

Function
REQ-019 SHALL form eff = trig_i & src_mask_i; a trigger request exists when eff != 0.
REQ-020 SHALL implement FSM states IDLE and HOLDOFF.
REQ-021 In IDLE with eff != 0 and at least one buffer free (hold_o evaluated at start of cycle), SHALL accept: next cycle digitize_o = 1, hold_o[b] = 1, digitize_buffer_o = b, digitize_source_o = eff (latency 1 clock).
REQ-022 Allocated buffer b SHALL be the first free index found searching circularly from wr_ptr; wr_ptr then becomes (b+1) mod NUM_BUF.
REQ-023 On accept, SHALL enter HOLDOFF for holdoff_i clocks, then return to IDLE; holdoff_i = 0 SHALL stay in IDLE, allowing back-to-back accepts each clock.
REQ-024 Triggers during HOLDOFF SHALL be ignored and not counted as lost.
REQ-025 In IDLE with eff != 0 and all buffers held, SHALL not accept and SHALL increment lost_count_o once per clock the condition holds, saturating at 0xFFFF.
REQ-026 clear_i SHALL clear hold_o[clear_buffer_i] on the next clock; clearing an unheld buffer or an index >= NUM_BUF SHALL have no effect.
REQ-027 Clear and accept in the same cycle SHALL both take effect; a clear SHALL NOT make its buffer available to a same-cycle trigger (full + clear + trigger -> lost).
REQ-028 dead_o SHALL equal (state == HOLDOFF) | (all hold_o set), registered.
REQ-029 dead_count_o SHALL increment each clock dead_o = 1, saturating at 0xFFFFFFFF.
REQ-030 src_mask_i = 0 SHALL suppress all accepts and lost counting.

Reset
REQ-031 On rst_n_i = 0 SHALL immediately force: state IDLE, wr_ptr 0, hold_o 0, digitize_o 0, digitize_buffer_o 0, digitize_source_o 0, dead_o 0, dead_count_o 0, lost_count_o 0.
REQ-032 Reset mid-holdoff or mid-digitize SHALL abandon the operation; no digitize_o pulse after deassertion without a new trigger.

Structure
REQ-033 Shared package SHALL hold the FSM state encoding and the count-width constants (32, 16).
REQ-034 SHALL contain one sub-module, trig_buf_alloc: combinational circular first-free search returning index and any-free flag.

Verification
REQ-035 Reset, holdoff_i = 4, trig_i = 0001 for one clock -> digitize_o pulse one clock later, buffer 0, source 0001, hold_o = 0001, dead_o high 4 clocks.
REQ-036 holdoff_i = 0, five consecutive trigger clocks, NUM_BUF = 4 -> buffers 0,1,2,3 allocated, hold_o = 1111, fifth trigger lost, lost_count_o = 1.
REQ-037 Buffers 0..3 held, clear buffer 1, then trigger -> buffer 1 allocated (circular search from wr_ptr = 0).
REQ-038 All full, clear_i and trigger in the same cycle -> no accept, lost_count_o +1, hold_o bit cleared next clock.
REQ-039 trig_i = 1111, src_mask_i = 0101 -> digitize_source_o = 0101; src_mask_i = 0 -> no digitize, counts unchanged.
REQ-040 rst_n_i asserted mid-holdoff with hold_o = 0011 -> all outputs zero asynchronously, no pulse after release.
